mem_bus_bridge: RTL and testbench
=================================

# mem_bus_bridge

Memory-side bridge between the multicycle control unit and a single external word-wide memory bus. It turns the control unit's one-state `memory_read`/`memory_write` pulses into a valid/ack bus transaction and selects the address (PC or ALU result) per `lorD`. Read data lands in the instruction register (IR) or memory data register (MDR). The bridge asserts `stall` to freeze the control unit and all datapath write enables until the access completes. It also flags misaligned and timed-out accesses.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles `bus_req` is held without `bus_ack`. Must be ≥1.
- `NOP_INSTR`, default 32'h00000013: value loaded into IR on reset and on a faulted fetch.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `memory_read` in 1: read request from the control unit.
- `memory_write` in 1: write request from the control unit.
- `lorD` in 1: address select. 0 selects `pc`; 1 selects `alu_addr`.
- `ir_write` in 1: when asserted with `memory_read`, the read targets IR. Otherwise reads target MDR.
- `pc` in 32: instruction address.
- `alu_addr` in 32: data address (registered ALU result).
- `store_data` in 32: write data (rs2 register).
- `bus_req` out 1: transaction valid, registered.
- `bus_we` out 1: 1 means write, registered.
- `bus_addr` out 32: word address, registered.
- `bus_wdata` out 32: write data, registered.
- `bus_ack` in 1: slave completion. Sampled only in REQ.
- `bus_rdata` in 32: read data. Valid when `bus_ack`=1.
- `instr` out 32: IR contents.
- `mdr` out 32: MDR contents.
- `stall` out 1: combinational. While high, the control unit state register and every datapath write must hold.
- `bus_error` out 1: sticky fault flag.

## Operation
- FSM states are IDLE, REQ and DONE.
- **IDLE**
  - `req` = `memory_read` | `memory_write`.
  - If `req` is high, capture the following fields:
    - addr = `lorD` ? `alu_addr` : `pc`.
    - we = `memory_write`. Write has priority if both request signals are high.
    - wdata = `store_data`.
    - dest = IR if (`ir_write` & `memory_read` & !`memory_write`), else MDR.
  - If addr[1:0] ≠ 0: set `bus_error`, issue no bus transaction, go to DONE. A read faulted here loads `NOP_INSTR` into IR (dest IR) or 0 into MDR (dest MDR). A write faulted here updates nothing.
  - Otherwise go to REQ with `bus_req`=1, `bus_addr`/`bus_we`/`bus_wdata` driven from the captured fields, and the timeout counter cleared to 0.
- **REQ**
  - `bus_req` and all bus fields are held stable.
  - On `bus_ack`=1:
    - A read latches `bus_rdata` into the dest register.
    - A write updates neither register.
    - `bus_req` drops to 0 and the FSM goes to DONE.
  - On `bus_ack`=0:
    - If counter == `TIMEOUT_CYCLES`-1: drop `bus_req`, set `bus_error`, load `NOP_INSTR`/0 as in the misaligned case, go to DONE.
    - Otherwise increment the counter.
- **DONE**
  - `stall`=0, so the control unit advances this cycle.
  - Request inputs are ignored. They still reflect the old state.
  - The FSM always goes to IDLE.
- `stall` = (IDLE & `req`) | REQ.
- `bus_ack` is ignored outside REQ.
- IR and MDR change only as described above.
- `bus_error` is cleared only by `rst`.
- **Reset values**
  - State = IDLE.
  - `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0.
  - `instr`=`NOP_INSTR`, `mdr`=0.
  - `bus_error`=0, timeout counter = 0.
  - Reset asserted mid-transaction aborts it in the next cycle: `bus_req` is low after that edge and no register is loaded.

## Timing
- Request seen in IDLE in cycle T: `stall`=1 in T. At T+1 the FSM is in REQ and `bus_req`=1.
- Ack sampled high in cycle T+k (k≥1): data is latched at the end of T+k. The FSM is in DONE at T+k+1 with `bus_req`=0 and `stall`=0. IDLE is reached at T+k+2.
- Minimum access time is 3 cycles (T, T+1, T+2) with a zero-wait ack.
- Timeout: `bus_req` stays high for exactly `TIMEOUT_CYCLES` cycles. If ack arrives in the final cycle, the ack wins and there is no error.
- Misaligned access: T is IDLE, T+1 is DONE. `bus_req` never rises.
- `instr`/`mdr` are valid from the first DONE cycle.

## Test plan
- Fetch: `memory_read`=1, `ir_write`=1, `lorD`=0, `pc`=0x10; slave acks at T+1 with 0x00500093. Expect `bus_addr`=0x10, `bus_we`=0, `stall` high for T and T+1, `instr`=0x00500093 at T+2, `mdr` unchanged.
- Load with 3 wait states: `lorD`=1, `alu_addr`=0x100, ack at T+4 with 0xDEADBEEF. Expect `bus_req` high for 4 cycles, `mdr`=0xDEADBEEF at T+5, `instr` unchanged.
- Store: `memory_write`=1, `alu_addr`=0x204, `store_data`=0xCAFE0001. Expect `bus_we`=1 and `bus_wdata`=0xCAFE0001 held until ack; `instr`/`mdr` unchanged.
- Timeout (`TIMEOUT_CYCLES`=4), no ack on a fetch. Expect `bus_req` high exactly 4 cycles, `bus_error`=1, `instr`=0x00000013. A second run acking in the 4th cycle gives no error.
- Misaligned load at 0x102. Expect `bus_req` never asserted, `stall` for 1 cycle, `bus_error`=1, `mdr`=0.
- `rst` pulsed at T+2 of a waiting access. Expect `bus_req`=0 and state IDLE after the edge, `instr`=0x00000013, and a late `bus_ack` ignored.

Source files
------------

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge
//
// Memory-side bridge between the multicycle control unit and a single
// word-wide external bus. One-cycle memory_read / memory_write requests from
// the control unit become a registered valid/ack bus transaction. Read data is
// steered into the instruction register (IR) or the memory data register
// (MDR). While an access is in flight, stall freezes the control unit and
// every datapath write enable. Misaligned and timed-out accesses raise a
// sticky bus_error and complete without data (IR gets NOP_INSTR, MDR gets 0).
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   memory_read/_write  : request pulses from the control unit
//   lorD                : address select (0 = pc, 1 = alu_addr)
//   ir_write            : read targets IR when set with memory_read
//   pc, alu_addr        : candidate addresses
//   store_data          : write data
//   bus_req/we/addr/wdata : registered bus request fields
//   bus_ack, bus_rdata  : slave completion and read data
//   instr, mdr          : IR and MDR contents
//   stall               : combinational hold for the control unit
//   bus_error           : sticky fault flag, cleared only by rst

module mem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic        lorD,
    input  logic        ir_write,
    input  logic [31:0] pc,
    input  logic [31:0] alu_addr,
    input  logic [31:0] store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic        stall,
    output logic        bus_error
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic          dest_ir_q, dest_ir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   mdr_q, mdr_d;
    logic          bus_error_q, bus_error_d;

    logic          req;
    logic [31:0]   req_addr;
    logic          req_we;
    logic          req_dest_ir;

    // Request decode from the control unit. Write wins when both are high,
    // and only a pure read with ir_write targets the IR.
    always_comb begin
        req         = memory_read | memory_write;
        req_addr    = lorD ? alu_addr : pc;
        req_we      = memory_write;
        req_dest_ir = ir_write & memory_read & ~memory_write;
    end

    // Next-state and register updates. A faulted read (misaligned or
    // timed out) still completes, loading a harmless NOP into IR or zero
    // into MDR so the control unit can advance without garbage.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        dest_ir_d   = dest_ir_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        mdr_d       = mdr_q;
        bus_error_d = bus_error_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (req_addr[1:0] != 2'b00) begin
                        bus_error_d = 1'b1;
                        state_d     = DONE;
                        if (!req_we) begin
                            if (req_dest_ir) instr_d = NOP_INSTR;
                            else             mdr_d   = 32'h0;
                        end
                    end else begin
                        state_d     = REQ;
                        bus_req_d   = 1'b1;
                        bus_addr_d  = req_addr;
                        bus_we_d    = req_we;
                        bus_wdata_d = store_data;
                        dest_ir_d   = req_dest_ir;
                        cnt_d       = '0;
                    end
                end
            end

            REQ: begin
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        if (dest_ir_q) instr_d = bus_rdata;
                        else           mdr_d   = bus_rdata;
                    end
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = DONE;
                    if (!bus_we_q) begin
                        if (dest_ir_q) instr_d = NOP_INSTR;
                        else           mdr_d   = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            dest_ir_q   <= 1'b0;
            cnt_q       <= '0;
            instr_q     <= NOP_INSTR;
            mdr_q       <= 32'h0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            dest_ir_q   <= dest_ir_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            mdr_q       <= mdr_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Stall covers the request cycle in IDLE and every REQ cycle; DONE
    // releases the control unit.
    always_comb begin
        stall = ((state_q == IDLE) & req) | (state_q == REQ);
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign instr     = instr_q;
    assign mdr       = mdr_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge
//
// Directed testbench for mem_bus_bridge with TIMEOUT_CYCLES = 4. Each step
// drives the request inputs just after a rising edge and samples outputs
// one time unit after the following edges; expected values are hand-computed.

module tb_mem_bus_bridge;

    logic        clk;
    logic        rst;
    logic        memory_read;
    logic        memory_write;
    logic        lorD;
    logic        ir_write;
    logic [31:0] pc;
    logic [31:0] alu_addr;
    logic [31:0] store_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        stall;
    logic        bus_error;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_bridge #(
        .TIMEOUT_CYCLES(4),
        .NOP_INSTR     (32'h00000013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memory_read (memory_read),
        .memory_write(memory_write),
        .lorD        (lorD),
        .ir_write    (ir_write),
        .pc          (pc),
        .alu_addr    (alu_addr),
        .store_data  (store_data),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .instr       (instr),
        .mdr         (mdr),
        .stall       (stall),
        .bus_error   (bus_error)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE (cycle T), confirm stall, move to T+1 and
    // withdraw the request so it cannot restart after DONE.
    task automatic issue(input string tag, input logic mr, input logic mw, input logic irw,
                         input logic lsel, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] sd);
        memory_read  = mr;
        memory_write = mw;
        ir_write     = irw;
        lorD         = lsel;
        pc           = p;
        alu_addr     = a;
        store_data   = sd;
        #1;
        check({tag, " stall@T"}, 32'(stall), 32'd1);
        tick();
        memory_read  = 1'b0;
        memory_write = 1'b0;
        ir_write     = 1'b0;
    endtask

    // Hold in REQ for waits cycles without ack, then ack with rdata. Checks
    // bus fields on every REQ cycle and the DONE cycle afterwards.
    task automatic req_phase(input string tag, input int waits, input logic [31:0] rdata,
                             input logic we_exp, input logic [31:0] addr_exp,
                             input logic [31:0] wdata_exp);
        for (int i = 0; i <= waits; i++) begin
            check({tag, " bus_req"}, 32'(bus_req), 32'd1);
            check({tag, " bus_addr"}, bus_addr, addr_exp);
            check({tag, " bus_we"}, 32'(bus_we), 32'(we_exp));
            if (we_exp) check({tag, " bus_wdata"}, bus_wdata, wdata_exp);
            check({tag, " stall@REQ"}, 32'(stall), 32'd1);
            if (i == waits) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
            end
            tick();
        end
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        check({tag, " bus_req@DONE"}, 32'(bus_req), 32'd0);
        check({tag, " stall@DONE"}, 32'(stall), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        memory_read  = 1'b0;
        memory_write = 1'b0;
        lorD         = 1'b0;
        ir_write     = 1'b0;
        pc           = 32'h0;
        alu_addr     = 32'h0;
        store_data   = 32'h0;
        bus_ack      = 1'b0;
        bus_rdata    = 32'h0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst bus_we", 32'(bus_we), 32'd0);
        check("rst bus_addr", bus_addr, 32'h0);
        check("rst bus_wdata", bus_wdata, 32'h0);
        check("rst instr", instr, 32'h00000013);
        check("rst mdr", mdr, 32'h0);
        check("rst bus_error", 32'(bus_error), 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        tick();

        // Fetch, zero-wait ack
        issue("fetch", 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
        req_phase("fetch", 0, 32'h00500093, 1'b0, 32'h10, 32'h0);
        check("fetch instr", instr, 32'h00500093);
        check("fetch mdr", mdr, 32'h0);
        tick();

        // Load with 3 wait states
        issue("load", 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h100, 32'h0);
        req_phase("load", 3, 32'hDEADBEEF, 1'b0, 32'h100, 32'h0);
        check("load mdr", mdr, 32'hDEADBEEF);
        check("load instr", instr, 32'h00500093);
        tick();

        // Store, one wait state
        issue("store", 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h204, 32'hCAFE0001);
        req_phase("store", 1, 32'h12345678, 1'b1, 32'h204, 32'hCAFE0001);
        check("store instr", instr, 32'h00500093);
        check("store mdr", mdr, 32'hDEADBEEF);
        tick();

        // Ack in the last allowed cycle wins over the timeout
        issue("lastack", 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0);
        req_phase("lastack", 3, 32'h11111111, 1'b0, 32'h20, 32'h0);
        check("lastack bus_error", 32'(bus_error), 32'd0);
        check("lastack instr", instr, 32'h11111111);
        tick();

        // Fetch timeout: bus_req high exactly 4 cycles
        issue("tmo", 1'b1, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("tmo bus_req", 32'(bus_req), 32'd1);
            tick();
        end
        check("tmo bus_req@DONE", 32'(bus_req), 32'd0);
        check("tmo stall@DONE", 32'(stall), 32'd0);
        check("tmo bus_error", 32'(bus_error), 32'd1);
        check("tmo instr", instr, 32'h00000013);
        check("tmo mdr", mdr, 32'hDEADBEEF);
        tick();

        // Clear the sticky error, then load a known MDR value
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2 bus_error", 32'(bus_error), 32'd0);
        tick();
        issue("preload", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h108, 32'h0);
        req_phase("preload", 0, 32'h55AA55AA, 1'b0, 32'h108, 32'h0);
        check("preload mdr", mdr, 32'h55AA55AA);
        tick();

        // Misaligned load: one stall cycle, no bus transaction
        issue("misalign", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h102, 32'h0);
        check("misalign bus_req", 32'(bus_req), 32'd0);
        check("misalign stall@DONE", 32'(stall), 32'd0);
        check("misalign bus_error", 32'(bus_error), 32'd1);
        check("misalign mdr", mdr, 32'h0);
        check("misalign instr", instr, 32'h00000013);
        tick();
        check("misalign bus_req@IDLE", 32'(bus_req), 32'd0);

        // Reset at T+2 of a waiting fetch, then a late ack
        issue("abort", 1'b1, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0);
        check("abort bus_req@T+1", 32'(bus_req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort bus_req", 32'(bus_req), 32'd0);
        check("abort stall", 32'(stall), 32'd0);
        check("abort instr", instr, 32'h00000013);
        check("abort bus_error", 32'(bus_error), 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_ack   = 1'b0;
        check("lateack instr", instr, 32'h00000013);
        check("lateack mdr", mdr, 32'h0);
        check("lateack bus_req", 32'(bus_req), 32'd0);
        check("lateack stall", 32'(stall), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
